// File: rtl/if_align_queue_pkg.sv
// Shared types and defaults for the fetch word queue / RVC realigner.
// Queue words carry their access-fault flag alongside the data.
package if_align_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    // Wide enough that drop can absorb several back-to-back redirects.
    localparam int CNT_W = 8;

    typedef struct packed {
        logic        fault;
        logic [31:0] data;
    } word_t;

    function automatic logic is_rvc(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_align_queue_word_fifo.sv
// Power-of-two word queue with two-entry peek; clear empties it in one cycle.
// Callers guarantee no push when full and no pop when empty.
module if_align_queue_word_fifo
    import if_align_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  word_t       push_word,
    input  logic        pop,
    output word_t       peek0,
    output logic        peek1_fault,
    output logic [15:0] peek1_half,
    output logic [AW:0] count
);

    word_t         mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;

    assign rd_next     = rd_ptr + 1'b1;
    assign peek0       = mem[rd_ptr];
    assign peek1_fault = mem[rd_next].fault;
    assign peek1_half  = mem[rd_next].data[15:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_align_queue.sv
// Fetch-side word queue and RVC realigner: issues word fetches, buffers the
// returned words and hands out one 16- or 32-bit instruction per handshake.
module if_align_queue
    import if_align_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_valid_o,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_fault_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_data_o,
    output logic        inst_is_rvc_o,
    output logic        inst_fault_o
);

    localparam int AW = $clog2(DEPTH);

    // Handshakes: a transfer happens in a cycle where valid && ready are both
    // high at the clock edge; valid never depends on ready, and the output
    // register holds valid and payload stable until the transfer completes.
    logic [29:0]      fetch_word;
    logic [31:0]      head_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic             halted;

    word_t       w0;
    logic        w1_fault;
    logic [15:0] w1_half;
    logic [AW:0] count;

    logic req_acc, rsp_take, rsp_drop, load;
    logic cand_valid, cand_fault, cand_rvc, cand_pop, cand_step4;
    logic [31:0] cand_data;

    assign mem_req_valid_o = !halted && ((CNT_W'(count) + outstanding) < CNT_W'(DEPTH));
    assign mem_req_addr_o  = {fetch_word, 2'b00};
    assign req_acc         = mem_req_valid_o && mem_req_ready_i;
    assign rsp_take        = mem_rvalid_i && (drop == '0);
    assign rsp_drop        = mem_rvalid_i && (drop != '0);

    if_align_queue_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush_i),
        .push        (rsp_take && !flush_i),
        .push_word   ('{fault: mem_fault_i, data: mem_rdata_i}),
        .pop         (load && cand_pop),
        .peek0       (w0),
        .peek1_fault (w1_fault),
        .peek1_half  (w1_half),
        .count       (count)
    );

    // Realign the next instruction at head_pc out of the first one or two words.
    always_comb begin
        cand_valid = 1'b0;
        cand_fault = 1'b0;
        cand_rvc   = 1'b0;
        cand_pop   = 1'b0;
        cand_step4 = 1'b0;
        cand_data  = '0;
        if (count != '0) begin
            if (w0.fault) begin
                cand_valid = 1'b1;
                cand_fault = 1'b1;
            end else if (!head_pc[1]) begin
                cand_valid = 1'b1;
                if (is_rvc(w0.data[15:0])) begin
                    cand_rvc  = 1'b1;
                    cand_data = {16'b0, w0.data[15:0]};
                end else begin
                    cand_data  = w0.data;
                    cand_pop   = 1'b1;
                    cand_step4 = 1'b1;
                end
            end else if (is_rvc(w0.data[31:16])) begin
                cand_valid = 1'b1;
                cand_rvc   = 1'b1;
                cand_data  = {16'b0, w0.data[31:16]};
                cand_pop   = 1'b1;
            end else if (count > (AW+1)'(1)) begin
                cand_valid = 1'b1;
                if (w1_fault) begin
                    cand_fault = 1'b1;
                end else begin
                    cand_data  = {w1_half, w0.data[31:16]};
                    cand_pop   = 1'b1;
                    cand_step4 = 1'b1;
                end
            end
        end
    end

    assign load = cand_valid && !halted && !flush_i && (!inst_valid_o || inst_ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_word    <= RESET_PC[31:2];
            head_pc       <= RESET_PC;
            outstanding   <= '0;
            drop          <= '0;
            halted        <= 1'b0;
            inst_valid_o  <= 1'b0;
            inst_pc_o     <= '0;
            inst_data_o   <= '0;
            inst_is_rvc_o <= 1'b0;
            inst_fault_o  <= 1'b0;
        end else if (flush_i) begin
            fetch_word   <= redirect_pc_i[31:2];
            head_pc      <= redirect_pc_i & 32'hFFFF_FFFE;
            halted       <= 1'b0;
            outstanding  <= '0;
            // Everything still in flight after this edge must be discarded.
            drop         <= drop + outstanding + CNT_W'(req_acc) - CNT_W'(mem_rvalid_i);
            inst_valid_o <= 1'b0;
        end else begin
            if (req_acc) fetch_word <= fetch_word + 1'b1;
            outstanding <= outstanding + CNT_W'(req_acc) - CNT_W'(rsp_take);
            if (rsp_drop) drop <= drop - 1'b1;
            if (load) begin
                inst_valid_o  <= 1'b1;
                inst_pc_o     <= head_pc;
                inst_data_o   <= cand_data;
                inst_is_rvc_o <= cand_rvc;
                inst_fault_o  <= cand_fault;
                if (cand_fault) halted <= 1'b1;
                else            head_pc <= head_pc + (cand_step4 ? 32'd4 : 32'd2);
            end else if (inst_ready_i) begin
                inst_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_align_queue.sv
// Bench for if_align_queue: a randomized memory responder plus a halfword-stream
// reference model that predicts the instruction sequence from any start PC.
module tb_if_align_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam int          EW       = 66;  // {fault, rvc, pc, data}

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_fault_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_data_o;
    logic        inst_is_rvc_o;
    logic        inst_fault_o;

    if_align_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .mem_fault_i     (mem_fault_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_pc_o       (inst_pc_o),
        .inst_data_o     (inst_data_o),
        .inst_is_rvc_o   (inst_is_rvc_o),
        .inst_fault_o    (inst_fault_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   mem [256];
    logic          mem_flt [256];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [31:0]   pend_q[$];
    logic [31:0]   acc_q[$];
    logic [31:0]   exp_fetch;
    int rdy_pct, rsp_pct, cons_pct, n_acc;
    int checks = 0;
    int errors = 0;

    // memory model: hashed word index so distinct regions hold distinct data
    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2] ^ a[31:24]);
    endfunction

    function automatic logic [15:0] half_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[widx(pc)];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic fault_at(input logic [31:0] pc);
        return mem_flt[widx(pc)];
    endfunction

    task automatic fill_mem(input int flt_pct);
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(1) == 1) mem[i][1:0] = 2'b11;
            if ($urandom_range(1) == 1) mem[i][17:16] = 2'b11;
            mem_flt[i] = ($urandom_range(99) < flt_pct);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] d, input logic f);
        mem[widx(a)]     = d;
        mem_flt[widx(a)] = f;
    endtask

    // reference model: walk the halfword stream from start and list instructions
    task automatic build_exp(input logic [31:0] start);
        logic [31:0] pc;
        logic [15:0] h;
        exp_q.delete();
        pc = {start[31:1], 1'b0};
        for (int i = 0; i < 600; i++) begin
            if (fault_at(pc)) begin
                exp_q.push_back({1'b1, 1'b0, pc, 32'h0});
                break;
            end
            h = half_at(pc);
            if (h[1:0] != 2'b11) begin
                exp_q.push_back({1'b0, 1'b1, pc, 16'h0, h});
                pc = pc + 32'd2;
            end else if (fault_at(pc + 32'd2)) begin
                exp_q.push_back({1'b1, 1'b0, pc, 32'h0});
                break;
            end else begin
                exp_q.push_back({1'b0, 1'b0, pc, half_at(pc + 32'd2), h});
                pc = pc + 32'd4;
            end
        end
    endtask

    // driver: one clock cycle of randomized memory / consumer behaviour plus scoreboard
    task automatic cycle();
        logic [31:0]   a;
        logic [EW-1:0] e;
        mem_req_ready_i = ($urandom_range(99) < rdy_pct);
        if (pend_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
            a = pend_q.pop_front();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem[widx(a)];
            mem_fault_i  = mem_flt[widx(a)];
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            mem_fault_i  = 1'($urandom_range(1));
        end
        inst_ready_i = !flush_i && ($urandom_range(99) < cons_pct);
        #1;
        if (mem_req_valid_o && mem_req_ready_i) begin
            checks++;
            if (mem_req_addr_o !== exp_fetch) begin
                errors++;
                $display("FAIL req_addr: got %h expected %h", mem_req_addr_o, exp_fetch);
            end
            exp_fetch = exp_fetch + 32'd4;
            pend_q.push_back(mem_req_addr_o);
            acc_q.push_back(mem_req_addr_o);
            n_acc++;
        end
        if (inst_valid_o && inst_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL inst_unexpected: got pc %h fault %0b, expected no instruction", inst_pc_o, inst_fault_o);
            end else begin
                e = exp_q.pop_front();
                if (e[65] || inst_fault_o) begin
                    if (inst_fault_o !== e[65] || inst_pc_o !== e[63:32]) begin
                        errors++;
                        $display("FAIL inst_fault: got fault %0b pc %h, expected fault %0b pc %h", inst_fault_o, inst_pc_o, e[65], e[63:32]);
                    end
                end else if ({inst_is_rvc_o, inst_pc_o, inst_data_o} !== e[64:0]) begin
                    errors++;
                    $display("FAIL inst: got rvc %0b pc %h data %h, expected rvc %0b pc %h data %h", inst_is_rvc_o, inst_pc_o, inst_data_o, e[64], e[63:32], e[31:0]);
                end
            end
            obs_q.push_back({inst_fault_o, inst_is_rvc_o, inst_pc_o, inst_data_o});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        mem_fault_i = 1'b0;
        inst_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pend_q.delete();
        acc_q.delete();
        obs_q.delete();
        exp_fetch = RESET_PC;
        build_exp(RESET_PC);
        n_acc = 0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush_i = 1'b1;
        redirect_pc_i = pc;
        cycle();
        flush_i = 1'b0;
        redirect_pc_i = $urandom;
        exp_fetch = {pc[31:2], 2'b00};
        build_exp(pc);
        acc_q.delete();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (obs_q.size() < n && cyc < budget) begin
            cycle();
            cyc++;
        end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d instructions, required %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        fill_mem(0);
        do_reset();
        rdy_pct = 100; rsp_pct = 60; cons_pct = 0;
        repeat (10) cycle();
        do_reset();
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== RESET_PC) begin
            errors++;
            $display("FAIL reset_req: got valid %0b addr %h, expected 1 %h", mem_req_valid_o, mem_req_addr_o, RESET_PC);
        end
        checks++;
        if ({inst_valid_o, inst_is_rvc_o, inst_fault_o} !== 3'b000 || inst_pc_o !== 32'h0 || inst_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst: got v%0b r%0b f%0b pc %h data %h, expected all zero", inst_valid_o, inst_is_rvc_o, inst_fault_o, inst_pc_o, inst_data_o);
        end
    endtask

    task automatic test_pair(input string name, input logic [31:0] w0, input logic [31:0] w1, input logic [EW-1:0] e0, input logic [EW-1:0] e1);
        fill_mem(0);
        set_word(32'h3000_0000, w0, 1'b0);
        set_word(32'h3000_0004, w1, 1'b0);
        do_reset();
        rdy_pct = 100; rsp_pct = 100; cons_pct = 100;
        run_until(2, 40, name);
        if (obs_q.size() >= 2) begin
            checks++;
            if (obs_q[0] !== e0) begin
                errors++;
                $display("FAIL %s_inst0: got %h expected %h", name, obs_q[0], e0);
            end
            checks++;
            if (obs_q[1] !== e1) begin
                errors++;
                $display("FAIL %s_inst1: got %h expected %h", name, obs_q[1], e1);
            end
        end
    endtask

    task automatic test_flush_drop();
        fill_mem(0);
        do_reset();
        rdy_pct = 100; rsp_pct = 0; cons_pct = 100;
        cycle();
        cycle();
        checks++;
        if (n_acc !== 2 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup: got %0d accepts valid %0b, expected 2 accepts valid 0", n_acc, inst_valid_o);
        end
        rdy_pct = 0;
        do_flush(32'h8000_0002);
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %0b expected 0", inst_valid_o);
        end
        rdy_pct = 100; rsp_pct = 100;
        run_until(1, 40, "flush");
        if (obs_q.size() >= 1 && acc_q.size() >= 1) begin
            checks++;
            if (acc_q[0] !== 32'h8000_0000 || obs_q[0][63:32] !== 32'h8000_0002 || obs_q[0][65] !== 1'b0) begin
                errors++;
                $display("FAIL flush_redirect: got req %h inst pc %h fault %0b, expected 80000000 80000002 0", acc_q[0], obs_q[0][63:32], obs_q[0][65]);
            end
        end
        run_until(10, 80, "flush_tail");
    endtask

    task automatic test_backpressure();
        logic [31:0] cap_pc, cap_data;
        int w;
        fill_mem(0);
        for (int i = 0; i < 16; i++) set_word(RESET_PC + 32'(4 * i), 32'h0000_0013, 1'b0);
        do_reset();
        rdy_pct = 100; rsp_pct = 100; cons_pct = 0;
        w = 0;
        while (!inst_valid_o && w < 20) begin
            cycle();
            w++;
        end
        cap_pc = inst_pc_o;
        cap_data = inst_data_o;
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== RESET_PC || inst_pc_o !== cap_pc || inst_data_o !== cap_data) begin
                errors++;
                $display("FAIL stall_hold: got v%0b pc %h data %h, expected 1 %h %h", inst_valid_o, inst_pc_o, inst_data_o, RESET_PC, cap_data);
            end
        end
        checks++;
        if (n_acc > DEPTH + 1 || n_acc < DEPTH || mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_depth: got %0d accepts req_valid %0b, expected %0d..%0d and 0", n_acc, mem_req_valid_o, DEPTH, DEPTH + 1);
        end
        cons_pct = 100;
        run_until(12, 60, "stall_release");
        if (obs_q.size() >= 12) begin
            checks++;
            if (obs_q[11][63:0] !== {RESET_PC + 32'd44, 32'h0000_0013}) begin
                errors++;
                $display("FAIL stall_release_seq: got %h expected %h", obs_q[11][63:0], {RESET_PC + 32'd44, 32'h0000_0013});
            end
        end
    endtask

    task automatic test_fault();
        fill_mem(0);
        set_word(32'h3000_0000, 32'h0000_0013, 1'b0);
        set_word(32'h3000_0004, 32'h0000_0013, 1'b0);
        set_word(32'h3000_0008, 32'h0000_0013, 1'b1);
        do_reset();
        rdy_pct = 100; rsp_pct = 100; cons_pct = 100;
        run_until(3, 40, "fault");
        if (obs_q.size() >= 3) begin
            checks++;
            if (obs_q[2][65] !== 1'b1 || obs_q[2][63:32] !== 32'h3000_0008) begin
                errors++;
                $display("FAIL fault_inst: got fault %0b pc %h, expected 1 30000008", obs_q[2][65], obs_q[2][63:32]);
            end
        end
        n_acc = 0;
        repeat (20) cycle();
        checks++;
        if (n_acc !== 0 || mem_req_valid_o !== 1'b0 || obs_q.size() !== 3) begin
            errors++;
            $display("FAIL fault_halt: got %0d requests req_valid %0b %0d insts, expected 0 0 3", n_acc, mem_req_valid_o, obs_q.size());
        end
        do_flush(32'h3000_0010);
        run_until(4, 40, "fault_flush");
        if (obs_q.size() >= 4) begin
            checks++;
            if (obs_q[3][65] !== 1'b0 || obs_q[3][63:32] !== 32'h3000_0010) begin
                errors++;
                $display("FAIL fault_resume: got fault %0b pc %h, expected 0 30000010", obs_q[3][65], obs_q[3][63:32]);
            end
        end
    endtask

    task automatic test_random();
        int total;
        total = 0;
        for (int r = 0; r < 12; r++) begin
            fill_mem(2);
            if ($urandom_range(2) == 0) do_reset();
            else do_flush($urandom);
            obs_q.delete();
            rdy_pct  = $urandom_range(100, 30);
            rsp_pct  = $urandom_range(100, 30);
            cons_pct = $urandom_range(100, 30);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(99) < 3) do_flush($urandom);
                else cycle();
            end
            total += obs_q.size();
        end
        checks++;
        if (total == 0) begin
            errors++;
            $display("FAIL random_progress: got %0d instructions, expected more than 0", total);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        redirect_pc_i = '0;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        mem_fault_i = 1'b0;
        inst_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_pair("aligned", 32'h0000_0013, 32'h0000_0013,
                  {1'b0, 1'b0, 32'h3000_0000, 32'h0000_0013}, {1'b0, 1'b0, 32'h3000_0004, 32'h0000_0013});
        test_pair("rvc_pair", 32'h4501_0505, 32'h0000_0013,
                  {1'b0, 1'b1, 32'h3000_0000, 32'h0000_0505}, {1'b0, 1'b1, 32'h3000_0002, 32'h0000_4501});
        test_pair("straddle", 32'h0013_0001, {16'($urandom), 16'h0000},
                  {1'b0, 1'b1, 32'h3000_0000, 32'h0000_0001}, {1'b0, 1'b0, 32'h3000_0002, 32'h0000_0013});
        test_flush_drop();
        test_backpressure();
        test_fault();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
